// File: rtl/hir_conv_pkg.sv
// Shared types and width helper for the parameterised 2-D convolution engine.
package hir_conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKload,
    StConv,
    StWrite,
    StDone
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hir_conv_tap_counter.sv
// Walks output pixels (r,c) and kernel taps (i,j,n) and flags tap validity and sequence ends.
module hir_conv_tap_counter #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned K     = 2,
  parameter int unsigned PAD   = 0,
  parameter int unsigned RW    = 3,
  parameter int unsigned CW    = 3,
  parameter int unsigned IW    = 1,
  parameter int unsigned KW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          tap_step_i,
  input  logic          pix_step_i,
  output logic [RW-1:0] r_o,
  output logic [CW-1:0] c_o,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [KW-1:0] n_o,
  output logic          in_range_o,
  output logic          last_tap_o,
  output logic          last_pixel_o
);

  localparam int unsigned RLast = (PAD != 0) ? IMG_H - 1 : IMG_H - K;
  localparam int unsigned CLast = (PAD != 0) ? IMG_W - 1 : IMG_W - K;

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [KW-1:0] n_q, n_d;

  assign last_tap_o   = (i_q == IW'(K - 1)) && (j_q == IW'(K - 1));
  assign last_pixel_o = (r_q == RW'(RLast)) && (c_q == CW'(CLast));
  assign in_range_o   = (PAD == 0) ||
                        (((32'(r_q) + 32'(i_q)) < IMG_H) && ((32'(c_q) + 32'(j_q)) < IMG_W));

  assign r_o = r_q;
  assign c_o = c_q;
  assign i_o = i_q;
  assign j_o = j_q;
  assign n_o = n_q;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    n_d = n_q;
    if (clear_i) begin
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
      n_d = '0;
    end else if (pix_step_i) begin
      i_d = '0;
      j_d = '0;
      n_d = '0;
      if (c_q == CW'(CLast)) begin
        c_d = '0;
        r_d = (r_q == RW'(RLast)) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end else if (tap_step_i) begin
      if (last_tap_o) begin
        i_d = '0;
        j_d = '0;
        n_d = '0;
      end else begin
        n_d = n_q + 1'b1;
        if (j_q == IW'(K - 1)) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q <= '0;
      c_q <= '0;
      i_q <= '0;
      j_q <= '0;
      n_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      i_q <= i_d;
      j_q <= j_d;
      n_q <= n_d;
    end
  end

endmodule

// File: rtl/hir_convolution_param.sv
// Sequential KxK convolution over an image memory: loads the kernel once, then one MAC per cycle.
module hir_convolution_param
  import hir_conv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 2,
  parameter int unsigned PAD    = 0,
  localparam int unsigned AW    = $clog2(IMG_W * IMG_H),
  localparam int unsigned KW    = clog2w(K * K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  output logic              busy,
  output logic              done,
  output logic              img_p0_addr_en,
  output logic [AW-1:0]     img_p0_addr_data,
  output logic              img_p0_rd_en,
  input  logic [DATA_W-1:0] img_p0_rd_data,
  output logic              kernel_p0_addr_en,
  output logic [KW-1:0]     kernel_p0_addr_data,
  output logic              kernel_p0_rd_en,
  input  logic [DATA_W-1:0] kernel_p0_rd_data,
  output logic              output_p0_addr_en,
  output logic [AW-1:0]     output_p0_addr_data,
  output logic              output_p0_wr_en,
  output logic [DATA_W-1:0] output_p0_wr_data
);

  localparam int unsigned NTap = K * K;
  localparam int unsigned RW   = clog2w(IMG_H);
  localparam int unsigned CW   = clog2w(IMG_W);
  localparam int unsigned IW   = clog2w(K);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] coef_q [NTap];
  logic [DATA_W-1:0] coef_d [NTap];
  logic [KW-1:0]     idx_q, idx_d;
  logic              ker_vld_q, ker_vld_d;
  logic              img_vld_q, img_vld_d;
  logic              drain_q, drain_d;

  logic          cnt_clear, tap_step, pix_step;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [IW-1:0] i, j;
  logic [KW-1:0] n;
  logic          in_range, last_tap, last_pixel;
  logic [AW-1:0] img_addr, out_addr;

  hir_conv_tap_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .PAD   (PAD),
    .RW    (RW),
    .CW    (CW),
    .IW    (IW),
    .KW    (KW)
  ) u_tap_counter (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (cnt_clear),
    .tap_step_i   (tap_step),
    .pix_step_i   (pix_step),
    .r_o          (r),
    .c_o          (c),
    .i_o          (i),
    .j_o          (j),
    .n_o          (n),
    .in_range_o   (in_range),
    .last_tap_o   (last_tap),
    .last_pixel_o (last_pixel)
  );

  assign img_addr = AW'((32'(r) + 32'(i)) * IMG_W + 32'(c) + 32'(j));
  assign out_addr = AW'(32'(r) * IMG_W + 32'(c));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    coef_d    = coef_q;
    idx_d     = n;
    ker_vld_d = 1'b0;
    img_vld_d = 1'b0;
    drain_d   = drain_q;
    cnt_clear = 1'b0;
    tap_step  = 1'b0;
    pix_step  = 1'b0;

    busy                = 1'b0;
    done                = 1'b0;
    img_p0_addr_en      = 1'b0;
    img_p0_addr_data    = '0;
    img_p0_rd_en        = 1'b0;
    kernel_p0_addr_en   = 1'b0;
    kernel_p0_addr_data = '0;
    kernel_p0_rd_en     = 1'b0;
    output_p0_addr_en   = 1'b0;
    output_p0_addr_data = '0;
    output_p0_wr_en     = 1'b0;
    output_p0_wr_data   = '0;

    // Read data lands one cycle after its request; idx_q remembers which tap it belongs to.
    if (ker_vld_q) coef_d[idx_q] = kernel_p0_rd_data;
    if (img_vld_q) acc_d = acc_q + coef_q[idx_q] * img_p0_rd_data;

    unique case (state_q)
      StIdle: begin
        cnt_clear = 1'b1;
        drain_d   = 1'b0;
        if (t) state_d = StKload;
      end
      StKload: begin
        busy = 1'b1;
        if (!drain_q) begin
          kernel_p0_addr_en   = 1'b1;
          kernel_p0_rd_en     = 1'b1;
          kernel_p0_addr_data = n;
          ker_vld_d           = 1'b1;
          tap_step            = 1'b1;
          if (last_tap) drain_d = 1'b1;
        end else begin
          cnt_clear = 1'b1;
          drain_d   = 1'b0;
          state_d   = StConv;
        end
      end
      StConv: begin
        busy = 1'b1;
        if (!drain_q) begin
          if (n == '0) acc_d = '0;
          tap_step = 1'b1;
          if (last_tap) drain_d = 1'b1;
          // Padded taps skip the read but still take their cycle.
          if (in_range) begin
            img_p0_addr_en   = 1'b1;
            img_p0_rd_en     = 1'b1;
            img_p0_addr_data = img_addr;
            img_vld_d        = 1'b1;
          end
        end else begin
          drain_d = 1'b0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy                = 1'b1;
        output_p0_addr_en   = 1'b1;
        output_p0_wr_en     = 1'b1;
        output_p0_addr_data = out_addr;
        output_p0_wr_data   = acc_q;
        pix_step            = 1'b1;
        state_d             = last_pixel ? StDone : StConv;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      coef_q    <= '{default: '0};
      idx_q     <= '0;
      ker_vld_q <= 1'b0;
      img_vld_q <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      coef_q    <= coef_d;
      idx_q     <= idx_d;
      ker_vld_q <= ker_vld_d;
      img_vld_q <= img_vld_d;
      drain_q   <= drain_d;
    end
  end

endmodule

// File: tb/tb_hir_convolution_param.sv
// Directed bench: one PAD=0 and one PAD=1 instance of the 8x8, K=2 convolution engine.
module tb_hir_convolution_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] t = '0;
  logic [1:0] busy, done;
  logic [1:0] img_addr_en, img_rd_en, ker_addr_en, ker_rd_en, out_addr_en, out_wr_en;
  logic [1:0][5:0]  img_addr, out_addr;
  logic [1:0][1:0]  ker_addr;
  logic [1:0][31:0] img_rdata, ker_rdata, out_wdata;

  logic [31:0] img_mem [64];
  logic [31:0] ker_mem [4];
  logic [31:0] out_mem [2][64];
  int          out_stamp [2][64];
  int          wr_cnt [2];
  int          proto_err [2];

  int n_cmp = 0;
  int n_err = 0;
  int dc, dn, ws, aw;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hir_convolution_param #(
      .DATA_W (32),
      .IMG_W  (8),
      .IMG_H  (8),
      .K      (2),
      .PAD    (g)
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .t                   (t[g]),
      .busy                (busy[g]),
      .done                (done[g]),
      .img_p0_addr_en      (img_addr_en[g]),
      .img_p0_addr_data    (img_addr[g]),
      .img_p0_rd_en        (img_rd_en[g]),
      .img_p0_rd_data      (img_rdata[g]),
      .kernel_p0_addr_en   (ker_addr_en[g]),
      .kernel_p0_addr_data (ker_addr[g]),
      .kernel_p0_rd_en     (ker_rd_en[g]),
      .kernel_p0_rd_data   (ker_rdata[g]),
      .output_p0_addr_en   (out_addr_en[g]),
      .output_p0_addr_data (out_addr[g]),
      .output_p0_wr_en     (out_wr_en[g]),
      .output_p0_wr_data   (out_wdata[g])
    );
  end

  // Synchronous memories plus interface-rule monitor.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (img_rd_en[k]) img_rdata[k] <= img_mem[img_addr[k]];
      if (ker_rd_en[k]) ker_rdata[k] <= ker_mem[ker_addr[k]];
      if (out_wr_en[k]) begin
        out_mem[k][out_addr[k]]   <= out_wdata[k];
        out_stamp[k][out_addr[k]] <= wr_cnt[k] + 1;
        wr_cnt[k]                 <= wr_cnt[k] + 1;
      end
      if ((img_addr_en[k] != img_rd_en[k]) || (!img_rd_en[k] && img_addr[k] != '0) ||
          (ker_addr_en[k] != ker_rd_en[k]) || (!ker_rd_en[k] && ker_addr[k] != '0) ||
          (out_addr_en[k] != out_wr_en[k]) ||
          (!out_wr_en[k] && (out_addr[k] != '0 || out_wdata[k] != '0)) ||
          (done[k] && busy[k]))
        proto_err[k] <= proto_err[k] + 1;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int n_written(input int k, input int start);
    int cnt = 0;
    for (int a = 0; a < 64; a++) if (out_stamp[k][a] > start) cnt++;
    return cnt;
  endfunction

  function automatic int n_other(input int k, input int start, input logic [31:0] val);
    int cnt = 0;
    for (int a = 0; a < 64; a++) if (out_stamp[k][a] > start && out_mem[k][a] != val) cnt++;
    return cnt;
  endfunction

  // Pulse t on instance k and watch 450 cycles; cycle 1 is the first cycle after the t edge.
  task automatic run_op(input int k, input int repulse, input int abort,
                        output int done_cyc, output int done_n, output int wr_start,
                        output int abort_wr);
    int cyc;
    done_cyc = -1;
    done_n   = 0;
    @(negedge clk);
    wr_start = wr_cnt[k];
    abort_wr = wr_start;
    t[k] = 1'b1;
    @(negedge clk);
    t[k] = 1'b0;
    cyc  = 1;
    check("busy_first_cycle", longint'(busy[k]), 1);
    while (cyc <= 450) begin
      if (done[k]) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort > 0 && cyc == abort + 1) begin
        check("abort_busy", longint'(busy[k]), 0);
        check("abort_wr_en", longint'(out_wr_en[k]), 0);
        check("abort_img_en", longint'(img_rd_en[k]), 0);
        abort_wr = wr_cnt[k];
      end
      t[k] = (cyc == repulse);
      rst  = (cyc != abort);
      @(negedge clk);
      cyc++;
    end
    t[k] = 1'b0;
    rst  = 1'b1;
  endtask

  task automatic load_ramp_kernel(input logic [31:0] k0, input logic [31:0] k1,
                                  input logic [31:0] k2, input logic [31:0] k3);
    for (int a = 0; a < 64; a++) img_mem[a] = 32'(a);
    ker_mem[0] = k0;
    ker_mem[1] = k1;
    ker_mem[2] = k2;
    ker_mem[3] = k3;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy[0]), 0);
    check("rst_done", longint'(done[0]), 0);
    check("rst_wr_en", longint'(out_wr_en[0]), 0);
    check("rst_img_en", longint'(img_rd_en[0]), 0);
    check("rst_busy_pad", longint'(busy[1]), 0);
    rst = 1'b1;
    @(negedge clk);

    // Ramp image, kernel 1..4: out(b) = 10*b + 62 for base address b.
    load_ramp_kernel(32'd1, 32'd2, 32'd3, 32'd4);
    run_op(0, 0, 0, dc, dn, ws, aw);
    check("valid_done_cycle", dc, 300);
    check("valid_done_count", dn, 1);
    check("valid_writes", n_written(0, ws), 49);
    check("valid_out0", longint'(out_mem[0][0]), 62);
    check("valid_out9", longint'(out_mem[0][9]), 152);
    check("valid_out54", longint'(out_mem[0][54]), 602);
    check("valid_skip_col7", longint'(out_stamp[0][7] > ws), 0);

    // Padded: out[7]=7+3*15, out[15]=15+3*23, out[56]=56+2*57, out[63]=63.
    run_op(1, 0, 0, dc, dn, ws, aw);
    check("pad_done_cycle", dc, 390);
    check("pad_writes", n_written(1, ws), 64);
    check("pad_out0", longint'(out_mem[1][0]), 62);
    check("pad_out7", longint'(out_mem[1][7]), 52);
    check("pad_out15", longint'(out_mem[1][15]), 84);
    check("pad_out56", longint'(out_mem[1][56]), 170);
    check("pad_out63", longint'(out_mem[1][63]), 63);

    // Kernel {-1,0,0,1}: img[b+9]-img[b] = 9 everywhere.
    load_ramp_kernel(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1);
    run_op(0, 0, 0, dc, dn, ws, aw);
    check("diff_done_cycle", dc, 300);
    check("diff_writes", n_written(0, ws), 49);
    check("diff_out0", longint'(out_mem[0][0]), 9);
    check("diff_not_nine", n_other(0, ws, 32'd9), 0);

    // 2 * 0x80000000 wraps to 0 per tap.
    for (int a = 0; a < 64; a++) img_mem[a] = 32'h8000_0000;
    for (int a = 0; a < 4; a++) ker_mem[a] = 32'd2;
    run_op(0, 0, 0, dc, dn, ws, aw);
    check("wrap_writes", n_written(0, ws), 49);
    check("wrap_out54", longint'(out_mem[0][54]), 0);
    check("wrap_nonzero", n_other(0, ws, 32'd0), 0);

    // t while busy is ignored.
    load_ramp_kernel(32'd1, 32'd2, 32'd3, 32'd4);
    run_op(0, 50, 0, dc, dn, ws, aw);
    check("repulse_done_cycle", dc, 300);
    check("repulse_done_count", dn, 1);
    check("repulse_writes", n_written(0, ws), 49);

    // Reset during CONV aborts silently; a fresh start then completes.
    run_op(0, 0, 100, dc, dn, ws, aw);
    check("abort_done_count", dn, 0);
    check("abort_late_writes", wr_cnt[0] - aw, 0);
    run_op(0, 0, 0, dc, dn, ws, aw);
    check("restart_done_cycle", dc, 300);
    check("restart_writes", n_written(0, ws), 49);
    check("restart_out54", longint'(out_mem[0][54]), 602);

    check("proto_pad0", proto_err[0], 0);
    check("proto_pad1", proto_err[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
